// File: rtl/dma_engineer_arbiter.sv
// Round-robin arbiter sharing one weight-fetch DMA engineer among N_REQ layer controllers.
// The grant is held from request through the end-of-packet beat; beats are steered to the owner.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction; pick the next requester round-robin
// REQ    | dma_engineer_req held with latched fields, waiting for the ack
// XFER   | beats routed to grant_id until the eop beat
module dma_engineer_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int ADDR_W = 27,
  parameter int DATA_W = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*ADDR_W-1:0]   start_addr_i,
  input  logic [N_REQ*ADDR_W-1:0]   length_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic [N_REQ-1:0]          dout_en_o,
  output logic [N_REQ-1:0]          dout_eop_o,
  output logic [DATA_W-1:0]         dout_o,
  output logic                      dma_engineer_req,
  output logic [ADDR_W-1:0]         dma_engineer_start_addr,
  output logic [ADDR_W-1:0]         dma_engineer_length,
  input  logic                      dma_engineer_ack,
  input  logic                      dma_engineer_dout_en,
  input  logic                      dma_engineer_dout_eop,
  input  logic [DATA_W-1:0]         dma_engineer_dout,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      proto_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [1:0]        r_state;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_grant_id;
  logic              r_dma_req;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_len;
  logic              r_proto_err;

  logic              w_any;
  logic [ID_W-1:0]   w_win;
  logic              w_ack_ok;
  logic              w_beat_ok;
  logic              w_violation;

  // Scan from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      if (req_i[(int'(r_last_grant) + off) % N_REQ]) begin
        w_any = 1'b1;
        w_win = ID_W'((int'(r_last_grant) + off) % N_REQ);
      end
    end
  end

  assign w_ack_ok    = (r_state == S_REQ)  && dma_engineer_ack;
  assign w_beat_ok   = (r_state == S_XFER) && dma_engineer_dout_en;
  assign w_violation = (dma_engineer_dout_en && (r_state != S_XFER)) ||
                       (dma_engineer_ack && (r_state != S_REQ));

  always_comb begin
    ack_o      = '0;
    dout_en_o  = '0;
    dout_eop_o = '0;
    if (w_ack_ok) begin
      ack_o[r_grant_id] = 1'b1;
    end
    if (w_beat_ok) begin
      dout_en_o[r_grant_id]  = 1'b1;
      dout_eop_o[r_grant_id] = dma_engineer_dout_eop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_grant_id   <= '0;
      r_dma_req    <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id <= w_win;
            r_addr     <= start_addr_i[w_win*ADDR_W +: ADDR_W];
            r_len      <= length_i[w_win*ADDR_W +: ADDR_W];
            r_dma_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (dma_engineer_ack) begin
            r_dma_req    <= 1'b0;
            r_last_grant <= r_grant_id;
            r_state      <= S_XFER;
          end
        end
        S_XFER: begin
          if (dma_engineer_dout_en && dma_engineer_dout_eop) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_violation) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign dout_o                  = dma_engineer_dout;
  assign dma_engineer_req        = r_dma_req;
  assign dma_engineer_start_addr = r_addr;
  assign dma_engineer_length     = r_len;
  assign grant_id                = r_grant_id;
  assign busy                    = (r_state != S_IDLE);
  assign proto_err               = r_proto_err;

endmodule

// File: tb/tb_dma_engineer_arbiter.sv
// Bench for dma_engineer_arbiter: drives requesters and a DMA engineer model,
// scoreboards expected grants and routed beats against what the arbiter produces.
module tb_dma_engineer_arbiter;
  localparam int N  = 4;
  localparam int IDW = 2;
  localparam int AW = 27;
  localparam int DW = 512;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_i;
  logic [N*AW-1:0]   start_addr_i;
  logic [N*AW-1:0]   length_i;
  logic [N-1:0]      ack_o;
  logic [N-1:0]      dout_en_o;
  logic [N-1:0]      dout_eop_o;
  logic [DW-1:0]     dout_o;
  logic              dma_engineer_req;
  logic [AW-1:0]     dma_engineer_start_addr;
  logic [AW-1:0]     dma_engineer_length;
  logic              dma_engineer_ack;
  logic              dma_engineer_dout_en;
  logic              dma_engineer_dout_eop;
  logic [DW-1:0]     dma_engineer_dout;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              proto_err;

  dma_engineer_arbiter #(.N_REQ(N), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .start_addr_i(start_addr_i), .length_i(length_i),
    .ack_o(ack_o), .dout_en_o(dout_en_o), .dout_eop_o(dout_eop_o), .dout_o(dout_o),
    .dma_engineer_req(dma_engineer_req), .dma_engineer_start_addr(dma_engineer_start_addr),
    .dma_engineer_length(dma_engineer_length), .dma_engineer_ack(dma_engineer_ack),
    .dma_engineer_dout_en(dma_engineer_dout_en), .dma_engineer_dout_eop(dma_engineer_dout_eop),
    .dma_engineer_dout(dma_engineer_dout), .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int port; logic [DW-1:0] data; logic eop; } beat_t;
  typedef struct { logic [IDW-1:0] id; logic [AW-1:0] addr; logic [AW-1:0] len; } grant_t;

  beat_t  beat_q[$];
  grant_t grant_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic prev_req = 1'b0;
  logic [N-1:0] exp_en;
  logic [N-1:0] exp_eop;
  beat_t  mb;
  grant_t mg;

  // Output monitor: every routed beat and every new DMA request is matched against the queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = dma_engineer_req;
    end else begin
      if (dout_en_o !== '0 || dout_eop_o !== '0) begin
        n_tests++;
        if (beat_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: dout_en_o=%b dout_eop_o=%b, required none", dout_en_o, dout_eop_o);
        end else begin
          mb = beat_q.pop_front();
          exp_en = '0;
          exp_en[mb.port] = 1'b1;
          exp_eop = mb.eop ? exp_en : '0;
          if (dout_en_o !== exp_en || dout_eop_o !== exp_eop || dout_o !== mb.data) begin
            n_fail++;
            $display("FAIL beat_route: en=%b eop=%b data=%h, required en=%b eop=%b data=%h",
                     dout_en_o, dout_eop_o, dout_o[31:0], exp_en, exp_eop, mb.data[31:0]);
          end
        end
      end
      if (dma_engineer_req && !prev_req) begin
        n_tests++;
        if (grant_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_grant: id=%0d addr=%h, required no request", grant_id, dma_engineer_start_addr);
        end else begin
          mg = grant_q.pop_front();
          if (grant_id !== mg.id || dma_engineer_start_addr !== mg.addr || dma_engineer_length !== mg.len) begin
            n_fail++;
            $display("FAIL grant: id=%0d addr=%h len=%0d, required id=%0d addr=%h len=%0d",
                     grant_id, dma_engineer_start_addr, dma_engineer_length, mg.id, mg.addr, mg.len);
          end
        end
      end
      prev_req = dma_engineer_req;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_i = '0;
    dma_engineer_ack = 1'b0;
    dma_engineer_dout_en = 1'b0;
    dma_engineer_dout_eop = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic push_grant(input int id, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    grant_t g;
    g.id = IDW'(id);
    g.addr = addr;
    g.len = len;
    grant_q.push_back(g);
  endtask

  // DMA engineer model: waits for the request, acks after ack_wait cycles, streams nbeats.
  task automatic serve(input int port, input int nbeats, input int ack_wait,
                       input bit perturb, input bit spurious, output int waited);
    beat_t b;
    logic [N-1:0] oh;
    oh = '0;
    oh[port] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!dma_engineer_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!dma_engineer_req) begin
      n_tests++;
      n_fail++;
      $display("FAIL serve_timeout port%0d: dma_engineer_req=0, required 1", port);
      return;
    end
    if (perturb) begin
      start_addr_i[port*AW +: AW] = start_addr_i[port*AW +: AW] ^ 27'h7FF;
      length_i[port*AW +: AW]     = length_i[port*AW +: AW] + 27'd9;
    end
    repeat (ack_wait) tick;
    dma_engineer_ack = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ack_o !== oh || dma_engineer_req !== 1'b1) begin
      n_fail++;
      $display("FAIL ack port%0d: ack_o=%b req=%b, required ack_o=%b req=1", port, ack_o, dma_engineer_req, oh);
    end
    tick;
    dma_engineer_ack = 1'b0;
    if (!perturb) req_i[port] = 1'b0;
    if (spurious) begin
      dma_engineer_ack = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ack_o !== '0) begin
        n_fail++;
        $display("FAIL spurious_ack: ack_o=%b, required 0000", ack_o);
      end
      tick;
      dma_engineer_ack = 1'b0;
    end
    for (int i = 0; i < nbeats; i++) begin
      b.port = port;
      b.data = {16{$urandom}};
      b.eop  = (i == nbeats - 1);
      dma_engineer_dout_en  = 1'b1;
      dma_engineer_dout_eop = b.eop;
      dma_engineer_dout     = b.data;
      beat_q.push_back(b);
      if (perturb && i == 2) req_i[port] = 1'b0;
      if (i == 0) begin
        @(negedge clk);
        n_tests++;
        if (dma_engineer_req !== 1'b0) begin
          n_fail++;
          $display("FAIL req_drop port%0d: dma_engineer_req=%b, required 0", port, dma_engineer_req);
        end
      end
      tick;
    end
    dma_engineer_dout_en  = 1'b0;
    dma_engineer_dout_eop = 1'b0;
  endtask

  task automatic test_reset;
    logic [DW-1:0] pat;
    rst = 1'b1;
    req_i = '0;
    start_addr_i = '0;
    length_i = '0;
    dma_engineer_ack = 1'b0;
    dma_engineer_dout_en = 1'b0;
    dma_engineer_dout_eop = 1'b0;
    dma_engineer_dout = '0;
    repeat (3) tick;
    rst = 1'b0;
    pat = {16{32'hA5C3_0F96}};
    dma_engineer_dout = pat;
    @(negedge clk);
    n_tests++;
    if ({dma_engineer_req, dma_engineer_start_addr, dma_engineer_length, grant_id, busy, proto_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: req=%b addr=%h len=%h gid=%0d busy=%b perr=%b, required all 0",
               dma_engineer_req, dma_engineer_start_addr, dma_engineer_length, grant_id, busy, proto_err);
    end
    n_tests++;
    if ({ack_o, dout_en_o, dout_eop_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_comb: ack=%b en=%b eop=%b, required all 0", ack_o, dout_en_o, dout_eop_o);
    end
    n_tests++;
    if (dout_o !== pat) begin
      n_fail++;
      $display("FAIL dout_passthru: dout_o=%h, required %h", dout_o[31:0], pat[31:0]);
    end
    tick;
  endtask

  task automatic test_single;
    int w;
    do_reset;
    start_addr_i[0 +: AW] = 27'h100;
    length_i[0 +: AW]     = 27'd13;
    push_grant(0, 27'h100, 27'd13);
    req_i = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (dma_engineer_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_req: dma_engineer_req=%b, required 0", dma_engineer_req);
    end
    serve(0, 13, 2, 1'b0, 1'b0, w);
    n_tests++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL single_latency: waited=%0d, required 0", w);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || beat_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_done: busy=%b pending_beats=%0d, required busy=0 pending=0", busy, beat_q.size());
    end
    tick;
  endtask

  task automatic test_round_robin;
    int w;
    int p;
    do_reset;
    for (int k = 0; k < N; k++) begin
      start_addr_i[k*AW +: AW] = AW'(32'h1000 * (k + 1));
      length_i[k*AW +: AW]     = AW'(2 + k);
    end
    for (int i = 0; i < 5; i++) begin
      p = i % N;
      push_grant(p, AW'(32'h1000 * (p + 1)), AW'(2 + p));
    end
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      p = i % N;
      serve(p, 2 + p, 1, 1'b0, 1'b0, w);
      req_i[p] = 1'b1;
    end
    req_i = '0;
    repeat (3) tick;
  endtask

  task automatic test_capture;
    int w;
    do_reset;
    start_addr_i[2*AW +: AW] = 27'h2A0;
    length_i[2*AW +: AW]     = 27'd6;
    push_grant(2, 27'h2A0, 27'd6);
    req_i = 4'b0100;
    serve(2, 6, 1, 1'b1, 1'b0, w);
    @(negedge clk);
    n_tests++;
    if (dma_engineer_start_addr !== 27'h2A0 || dma_engineer_length !== 27'd6) begin
      n_fail++;
      $display("FAIL capture: addr=%h len=%0d, required addr=2a0 len=6", dma_engineer_start_addr, dma_engineer_length);
    end
    tick;
  endtask

  task automatic test_proto_err;
    int w;
    do_reset;
    @(negedge clk);
    n_tests++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_clear: proto_err=%b, required 0", proto_err);
    end
    tick;
    dma_engineer_dout_en  = 1'b1;
    dma_engineer_dout_eop = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dout_en_o !== '0) begin
      n_fail++;
      $display("FAIL idle_beat_drop: dout_en_o=%b, required 0000", dout_en_o);
    end
    tick;
    dma_engineer_dout_en  = 1'b0;
    dma_engineer_dout_eop = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    n_tests++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_idle_beat: proto_err=%b busy=%b, required proto_err=1 busy=0", proto_err, busy);
    end
    tick;
    do_reset;
    start_addr_i[1*AW +: AW] = 27'h77;
    length_i[1*AW +: AW]     = 27'd3;
    push_grant(1, 27'h77, 27'd3);
    req_i = 4'b0010;
    serve(1, 3, 1, 1'b0, 1'b1, w);
    @(negedge clk);
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_spurious_ack: proto_err=%b, required 1", proto_err);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int w;
    beat_t b;
    do_reset;
    start_addr_i[0 +: AW] = 27'h300;
    length_i[0 +: AW]     = 27'd13;
    push_grant(0, 27'h300, 27'd13);
    req_i = 4'b0001;
    w = 0;
    @(negedge clk);
    while (!dma_engineer_req && w < 50) begin
      @(negedge clk);
      w++;
    end
    tick;
    dma_engineer_ack = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ack_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_ack: ack_o=%b, required 0001", ack_o);
    end
    tick;
    dma_engineer_ack = 1'b0;
    req_i = '0;
    for (int i = 0; i < 5; i++) begin
      b.port = 0;
      b.data = {16{$urandom}};
      b.eop  = 1'b0;
      dma_engineer_dout_en  = 1'b1;
      dma_engineer_dout_eop = 1'b0;
      dma_engineer_dout     = b.data;
      beat_q.push_back(b);
      tick;
    end
    dma_engineer_dout_en = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dma_engineer_req, dma_engineer_start_addr, dma_engineer_length, grant_id, busy, proto_err,
         ack_o, dout_en_o, dout_eop_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b addr=%h len=%h gid=%0d busy=%b perr=%b en=%b, required all 0",
               dma_engineer_req, dma_engineer_start_addr, dma_engineer_length, grant_id, busy, proto_err, dout_en_o);
    end
    tick;
    dma_engineer_dout_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dout_en_o !== '0) begin
      n_fail++;
      $display("FAIL stale_beat_drop: dout_en_o=%b, required 0000", dout_en_o);
    end
    tick;
    dma_engineer_dout_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_beat_perr: proto_err=%b, required 1", proto_err);
    end
    tick;
    start_addr_i[2*AW +: AW] = 27'h520;
    length_i[2*AW +: AW]     = 27'd4;
    push_grant(2, 27'h520, 27'd4);
    req_i = 4'b0100;
    serve(2, 4, 1, 1'b0, 1'b0, w);
  endtask

  task automatic test_back_to_back;
    int w0;
    int w1;
    do_reset;
    start_addr_i[0 +: AW]  = 27'h40;
    length_i[0 +: AW]      = 27'd3;
    start_addr_i[AW +: AW] = 27'h80;
    length_i[AW +: AW]     = 27'd5;
    push_grant(0, 27'h40, 27'd3);
    push_grant(1, 27'h80, 27'd5);
    req_i = 4'b0011;
    serve(0, 3, 1, 1'b0, 1'b0, w0);
    serve(1, 5, 1, 1'b0, 1'b0, w1);
    n_tests++;
    if (w1 !== 1) begin
      n_fail++;
      $display("FAIL turnaround: waited=%0d cycles after eop+1, required 1", w1);
    end
    repeat (2) tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_capture;
    test_proto_err;
    test_reset_mid;
    test_back_to_back;
    n_tests++;
    if (beat_q.size() != 0 || grant_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: beats=%0d grants=%0d, required 0 and 0", beat_q.size(), grant_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
